// File: rtl/breadboard_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : breadboard_sweeper
//  Description : Stimulus/check engine for the 4-input, 10-output breadboard
//                function block. Steps {w,x,y,z} through all 16 codes, holds
//                each code for a settle interval, samples r[9:0], and compares
//                the sample to the golden function table. Reports pass/fail,
//                the error count and the first failing code with its diff.
//  Revision    : 1.0 - initial release
// ============================================================================
module breadboard_sweeper #(
    parameter int SETTLE_CYCLES = 2,
    parameter bit STOP_ON_FAIL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       w,
    output logic       x,
    output logic       y,
    output logic       z,
    input  logic [9:0] r,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail_idx,
    output logic [9:0] first_fail_diff
);

    // Settle counter just needs to reach SETTLE_CYCLES-1; keep it at least 1 bit.
    localparam int c_wait_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(SETTLE_CYCLES - 1);
    localparam logic [c_wait_w-1:0] c_wait_one  = c_wait_w'(1);
    localparam logic [3:0]          c_idx_last  = 4'd15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              r_state;
    logic [3:0]          r_idx;
    logic [c_wait_w-1:0] r_wait;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [4:0]          r_err_count;
    logic [3:0]          r_first_fail_idx;
    logic [9:0]          r_first_fail_diff;

    logic [9:0]          w_golden;
    logic [9:0]          w_diff;
    logic                w_mismatch;
    logic [4:0]          w_err_next;
    logic [2:0]          w_ones;
    logic                w_a, w_b, w_c, w_d;

    // Golden function table evaluated for the code currently driven.
    always_comb begin
        w_a    = r_idx[3];
        w_b    = r_idx[2];
        w_c    = r_idx[1];
        w_d    = r_idx[0];
        w_ones = {2'b00, w_a} + {2'b00, w_b} + {2'b00, w_c} + {2'b00, w_d};
        w_golden    = '0;
        w_golden[0] = (w_a & w_b) | (w_a & w_d) | (w_b & w_c) | (w_c & w_d);
        w_golden[1] = (w_a & w_b) | (w_b & w_d) | (w_c & w_d);
        w_golden[2] = (w_ones >= 3'd3);
        w_golden[3] = (w_a & w_d) | (w_b & w_c);
        w_golden[4] = w_c & w_d;
        w_golden[5] = (~w_a & ~w_b) | (~w_c & ~w_d);
        w_golden[6] = (~w_a & ~w_b & w_c) | (~w_a & ~w_c & w_d) |
                      (w_b & ~w_c & w_d) | (w_a & ~w_b & ~w_c & ~w_d);
        w_golden[7] = (w_ones == 3'd2);
        w_golden[8] = w_c & w_d;
        w_golden[9] = ^r_idx;
    end

    assign w_diff     = r ^ w_golden;
    assign w_mismatch = |w_diff;
    assign w_err_next = r_err_count + {4'd0, w_mismatch};

    // Sweep sequencer: settle each code, sample, accumulate results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= IDLE;
            r_idx             <= '0;
            r_wait            <= '0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_count       <= '0;
            r_first_fail_idx  <= '0;
            r_first_fail_diff <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state           <= SETTLE;
                        r_idx             <= '0;
                        r_wait            <= '0;
                        r_busy            <= 1'b1;
                        r_done            <= 1'b0;
                        r_pass            <= 1'b0;
                        r_err_count       <= '0;
                        r_first_fail_idx  <= '0;
                        r_first_fail_diff <= '0;
                    end
                end
                SETTLE: begin
                    if (r_wait == c_wait_last) begin
                        r_state <= SAMPLE;
                    end else begin
                        r_wait <= r_wait + c_wait_one;
                    end
                end
                SAMPLE: begin
                    if (w_mismatch) begin
                        r_err_count <= w_err_next;
                        // Only the first mismatch of a sweep is recorded.
                        if (r_err_count == 5'd0) begin
                            r_first_fail_idx  <= r_idx;
                            r_first_fail_diff <= w_diff;
                        end
                    end
                    if ((r_idx == c_idx_last) || (STOP_ON_FAIL && w_mismatch)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 5'd0);
                    end else begin
                        r_idx   <= r_idx + 4'd1;
                        r_wait  <= '0;
                        r_state <= SETTLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign {w, x, y, z}    = r_idx;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err_count;
    assign first_fail_idx  = r_first_fail_idx;
    assign first_fail_diff = r_first_fail_diff;

endmodule
`default_nettype wire
